// File: rtl/fma16_pkg.sv
// Shared types for the fma16 issue stage: opcodes, fma16 control bits, queued request and decoder.
package fma16_pkg;

    typedef enum logic [2:0] {
        FADD       = 3'd0,
        FSUB       = 3'd1,
        FMUL       = 3'd2,
        FMADD      = 3'd3,
        FMSUB      = 3'd4,
        FNMADD     = 3'd5,
        FNMSUB     = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_e;

    typedef struct packed {
        logic mul;
        logic add;
        logic negr;
        logic negz;
    } fma16_ctl_t;

    typedef struct packed {
        fma16_ctl_t  ctl;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [1:0]  rm;
    } fma16_req_t;

    function automatic fma16_ctl_t decode_op(op_e op);
        fma16_ctl_t ctl;
        ctl = '0;
        case (op)
            FADD:    ctl = '{mul: 1'b0, add: 1'b1, negr: 1'b0, negz: 1'b0};
            FSUB:    ctl = '{mul: 1'b0, add: 1'b1, negr: 1'b0, negz: 1'b1};
            FMUL:    ctl = '{mul: 1'b1, add: 1'b0, negr: 1'b0, negz: 1'b0};
            FMADD:   ctl = '{mul: 1'b1, add: 1'b1, negr: 1'b0, negz: 1'b0};
            FMSUB:   ctl = '{mul: 1'b1, add: 1'b1, negr: 1'b0, negz: 1'b1};
            FNMADD:  ctl = '{mul: 1'b1, add: 1'b1, negr: 1'b1, negz: 1'b0};
            FNMSUB:  ctl = '{mul: 1'b1, add: 1'b1, negr: 1'b1, negz: 1'b1};
            default: ctl = '0;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/fma16_issue_if.sv
// Upstream request bus and downstream fma16 operand bus of the issue stage.
interface fma16_issue_if #(
    parameter int unsigned CNTW = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [15:0]     in_x;
    logic [15:0]     in_y;
    logic [15:0]     in_z;
    logic [1:0]      in_rm;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     x;
    logic [15:0]     y;
    logic [15:0]     z;
    logic            mul;
    logic            add;
    logic            negr;
    logic            negz;
    logic [1:0]      roundmode;
    logic            illegal_err;
    logic [CNTW-1:0] issue_cnt;

    modport slave (
        input  in_valid, in_op, in_x, in_y, in_z, in_rm, out_ready,
        output in_ready, out_valid, x, y, z, mul, add, negr, negz, roundmode,
               illegal_err, issue_cnt
    );

    modport master (
        output in_valid, in_op, in_x, in_y, in_z, in_rm, out_ready,
        input  in_ready, out_valid, x, y, z, mul, add, negr, negz, roundmode,
               illegal_err, issue_cnt
    );
endinterface

// File: rtl/fma16_issue_fifo.sv
// Synchronous DEPTH-entry FIFO of fma16 requests; storage is not reset.
module fma16_issue_fifo
    import fma16_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    input  fma16_req_t wdata,
    output logic       full,
    output logic       empty,
    output fma16_req_t head
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    fma16_req_t      mem [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push, do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/fma16_issue.sv
// fma16 operand issue stage: decodes opcodes, queues requests, presents the head to fma16.
module fma16_issue
    import fma16_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNTW  = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    fma16_issue_if.slave bus
);
    op_e             op;
    fma16_req_t      wr_req, head;
    logic            full, empty, accept, push, pop;
    logic            illegal_q;
    logic [CNTW-1:0] issue_cnt_q;

    assign op     = op_e'(bus.in_op);
    assign accept = bus.in_valid & ~full;
    assign push   = accept & (op != OP_ILLEGAL);
    assign pop    = ~empty & bus.out_ready;

    always_comb begin
        wr_req     = '0;
        wr_req.ctl = decode_op(op);
        wr_req.x   = bus.in_x;
        wr_req.y   = bus.in_y;
        wr_req.z   = bus.in_z;
        wr_req.rm  = bus.in_rm;
    end

    fma16_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   (wr_req),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_q   <= 1'b0;
            issue_cnt_q <= '0;
        end else begin
            if (accept && op == OP_ILLEGAL) illegal_q <= 1'b1;
            if (pop) issue_cnt_q <= issue_cnt_q + CNTW'(1);
        end
    end

    // Unreset storage is hidden behind empty so fma16 sees +0 with no operation.
    always_comb begin
        bus.x         = '0;
        bus.y         = '0;
        bus.z         = '0;
        bus.roundmode = '0;
        bus.mul       = 1'b0;
        bus.add       = 1'b0;
        bus.negr      = 1'b0;
        bus.negz      = 1'b0;
        if (!empty) begin
            bus.x         = head.x;
            bus.y         = head.y;
            bus.z         = head.z;
            bus.roundmode = head.rm;
            bus.mul       = head.ctl.mul;
            bus.add       = head.ctl.add;
            bus.negr      = head.ctl.negr;
            bus.negz      = head.ctl.negz;
        end
    end

    assign bus.in_ready    = ~full;
    assign bus.out_valid   = ~empty;
    assign bus.illegal_err = illegal_q;
    assign bus.issue_cnt   = issue_cnt_q;
endmodule

// File: tb/tb_fma16_issue.sv
// Directed bench for fma16_issue: reset, latency, full/back-pressure, streaming, decode, async reset.
module tb_fma16_issue;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    fma16_issue_if #(.CNTW(16)) bus ();

    fma16_issue #(
        .DEPTH (4),
        .CNTW  (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_x      = 16'h0;
        bus.in_y      = 16'h0;
        bus.in_z      = 16'h0;
        bus.in_rm     = 2'd0;
        bus.out_ready = 1'b0;
    endtask

    task automatic drive(input logic [2:0] op, input logic [15:0] xv, input logic [15:0] yv,
                         input logic [15:0] zv, input logic [1:0] rm);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_x     = xv;
        bus.in_y     = yv;
        bus.in_z     = zv;
        bus.in_rm    = rm;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
        end
        checks++;
        if ({bus.x, bus.y, bus.z} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data: xyz=%h, want 0", {bus.x, bus.y, bus.z});
        end
        checks++;
        if ({bus.mul, bus.add, bus.negr, bus.negz} !== 4'b0000 || bus.issue_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_ctl: ctl=%b cnt=%0d, want 0000 0",
                     {bus.mul, bus.add, bus.negr, bus.negz}, bus.issue_cnt);
        end
    endtask

    task automatic test_push_fmadd();
        drive(3'd3, 16'h3C00, 16'h4000, 16'h3C00, 2'd0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_flow_through: out_valid=%b, want 0", bus.out_valid);
        end
        tick();
        idle();
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.x, bus.y, bus.z} !== {16'h3C00, 16'h4000, 16'h3C00}) begin
            errors++;
            $display("FAIL fmadd_data: valid=%b xyz=%h, want 1 3c0040003c00",
                     bus.out_valid, {bus.x, bus.y, bus.z});
        end
        checks++;
        if ({bus.mul, bus.add, bus.negr, bus.negz} !== 4'b1100 || bus.roundmode !== 2'd0) begin
            errors++;
            $display("FAIL fmadd_ctl: ctl=%b rm=%0d, want 1100 0",
                     {bus.mul, bus.add, bus.negr, bus.negz}, bus.roundmode);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(3'd0, 16'(i), 16'h0, 16'h0, 2'd0);
            tick();
        end
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full: in_ready=%b out_valid=%b, want 0 1", bus.in_ready, bus.out_valid);
        end
        drive(3'd7, 16'h0, 16'h0, 16'h0, 2'd0);
        tick();
        checks++;
        if (bus.illegal_err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_while_full: illegal_err=%b, want 0", bus.illegal_err);
        end
        drive(3'd2, 16'd5, 16'h0, 16'h0, 2'd0);
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.x !== 16'd1) begin
            errors++;
            $display("FAIL held_off: in_ready=%b x=%h, want 0 0001", bus.in_ready, bus.x);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.x !== 16'd2) begin
            errors++;
            $display("FAIL pop_no_early_slot: in_ready=%b x=%h, want 1 0002", bus.in_ready, bus.x);
        end
        tick();
        bus.in_valid = 1'b0;
        for (int e = 3; e <= 4; e++) begin
            checks++;
            if (bus.x !== 16'(e) || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL drain_order: x=%h valid=%b, want %h 1", bus.x, bus.out_valid, 16'(e));
            end
            tick();
        end
        checks++;
        if (bus.issue_cnt !== 16'd4 || bus.x !== 16'd5 || bus.mul !== 1'b1 || bus.add !== 1'b0) begin
            errors++;
            $display("FAIL drain_tail: cnt=%0d x=%h mul=%b add=%b, want 4 0005 1 0",
                     bus.issue_cnt, bus.x, bus.mul, bus.add);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.issue_cnt !== 16'd5 || bus.x !== 16'h0) begin
            errors++;
            $display("FAIL drain_empty: valid=%b cnt=%0d x=%h, want 0 5 0000",
                     bus.out_valid, bus.issue_cnt, bus.x);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(3'd0, 16'h0100, 16'h0, 16'h0, 2'd0);
        tick();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            bus.in_x = 16'h0100 + 16'(i);
            tick();
            checks++;
            if (bus.x !== 16'h0100 + 16'(i) || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream: x=%h valid=%b ready=%b, want %h 1 1",
                         bus.x, bus.out_valid, bus.in_ready, 16'h0100 + 16'(i));
            end
        end
        checks++;
        if (bus.issue_cnt !== 16'd10) begin
            errors++;
            $display("FAIL stream_cnt: issue_cnt=%0d, want 10", bus.issue_cnt);
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.issue_cnt !== 16'd11) begin
            errors++;
            $display("FAIL stream_end: valid=%b cnt=%0d, want 0 11", bus.out_valid, bus.issue_cnt);
        end
        idle();
    endtask

    task automatic test_illegal_decode();
        logic [3:0] exp_ctl [7];
        exp_ctl = '{4'b0100, 4'b0101, 4'b1000, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
        do_reset();
        drive(3'd7, 16'h1234, 16'h1234, 16'h1234, 2'd1);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_ready: in_ready=%b, want 1", bus.in_ready);
        end
        tick();
        idle();
        checks++;
        if (bus.illegal_err !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal: err=%b valid=%b, want 1 0", bus.illegal_err, bus.out_valid);
        end
        for (int op = 0; op < 7; op++) begin
            drive(3'(op), 16'h1000 + 16'(op), 16'h2000 + 16'(op), 16'h3000 + 16'(op), 2'(op));
            tick();
            idle();
            checks++;
            if ({bus.mul, bus.add, bus.negr, bus.negz} !== exp_ctl[op] ||
                bus.z !== 16'h3000 + 16'(op) || bus.roundmode !== 2'(op)) begin
                errors++;
                $display("FAIL decode op%0d: ctl=%b z=%h rm=%0d, want %b %h %0d", op,
                         {bus.mul, bus.add, bus.negr, bus.negz}, bus.z, bus.roundmode,
                         exp_ctl[op], 16'h3000 + 16'(op), 2'(op));
            end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
        checks++;
        if (bus.illegal_err !== 1'b1 || bus.issue_cnt !== 16'd7) begin
            errors++;
            $display("FAIL illegal_sticky: err=%b cnt=%0d, want 1 7", bus.illegal_err, bus.issue_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(3'd7, 16'h0, 16'h0, 16'h0, 2'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(3'd6, 16'hAAA0 + 16'(i), 16'h5555, 16'h7777, 2'd3);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.illegal_err !== 1'b0 ||
            bus.issue_cnt !== 16'd0) begin
            errors++;
            $display("FAIL async_reset_state: valid=%b ready=%b err=%b cnt=%0d, want 0 1 0 0",
                     bus.out_valid, bus.in_ready, bus.illegal_err, bus.issue_cnt);
        end
        checks++;
        if ({bus.x, bus.y, bus.z, bus.roundmode, bus.mul, bus.add, bus.negr, bus.negz} !== 54'h0)
        begin
            errors++;
            $display("FAIL async_reset_data: out=%h, want 0",
                     {bus.x, bus.y, bus.z, bus.roundmode, bus.mul, bus.add, bus.negr, bus.negz});
        end
        tick();
        idle();
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.issue_cnt !== 16'd0 || bus.x !== 16'h0) begin
            errors++;
            $display("FAIL no_stale: valid=%b cnt=%0d x=%h, want 0 0 0000",
                     bus.out_valid, bus.issue_cnt, bus.x);
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_push_fmadd();
        test_fill();
        test_back_to_back();
        test_illegal_decode();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
